// File: rtl/sram_pkg.sv
// Shared constants and encodings for the SRAM port arbiter slice.
package sram_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LOCK_H = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  localparam logic REQ_H = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// One requester's access port into the SRAM arbiter (host or DPU side).
interface sram_port_arbiter_if #(
  parameter int ADDR_W = sram_pkg::ADDR_W,
  parameter int DATA_W = sram_pkg::DATA_W
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_rd_return.sv
// Read-return pipe: tags each issued read with its owner and routes the
// macro output two cycles later into that owner's rdata/rvalid registers.
module sram_rd_return #(
  parameter int DATA_W = sram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_issue,
  input  logic              rd_owner,
  input  logic [DATA_W-1:0] dout,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);
  import sram_pkg::*;

  logic p_vld;
  logic p_own;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld    <= 1'b0;
      p_own    <= REQ_H;
      h_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      h_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      p_vld    <= rd_issue;
      p_own    <= rd_owner;
      h_rvalid <= p_vld && (p_own == REQ_H);
      d_rvalid <= p_vld && (p_own == REQ_D);
      // rdata holds its value until the same owner's next read returns
      if (p_vld && (p_own == REQ_H)) h_rdata <= dout;
      if (p_vld && (p_own == REQ_D)) d_rdata <= dout;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between host and DPU,
// with an ownership lock and a lock timeout.
//   state  | meaning
//   FREE   | round-robin between host and DPU
//   LOCK_H | host holds the macro; DPU is blocked
//   LOCK_D | DPU holds the macro; host is blocked
module sram_port_arbiter #(
  parameter int ADDR_W   = sram_pkg::ADDR_W,
  parameter int DATA_W   = sram_pkg::DATA_W,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_port_arbiter_if.slave  h_port,
  sram_port_arbiter_if.slave  d_port,
  output logic                csb_n,
  output logic                we_n,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   din,
  input  logic [DATA_W-1:0]   dout,
  output logic                lock_err
);
  import sram_pkg::*;

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state;
  logic             rr_d;        // 1: DPU wins the next tie
  logic [CNT_W-1:0] lock_cnt;
  logic             h_sel;
  logic             d_sel;
  logic             own_sel;
  logic             own_lock;

  always_comb begin
    h_sel = 1'b0;
    d_sel = 1'b0;
    if (rst_n) begin
      case (state)
        FREE: begin
          if (h_port.req && (!d_port.req || !rr_d)) h_sel = 1'b1;
          else if (d_port.req)                      d_sel = 1'b1;
        end
        LOCK_H:  h_sel = h_port.req;
        LOCK_D:  d_sel = d_port.req;
        default: ;
      endcase
    end
  end

  assign h_port.gnt = h_sel;
  assign d_port.gnt = d_sel;

  always_comb begin
    csb_n = 1'b1;
    we_n  = 1'b1;
    addr  = '0;
    din   = '0;
    if (h_sel) begin
      csb_n = 1'b0;
      we_n  = ~h_port.we;
      addr  = h_port.addr;
      din   = h_port.we ? h_port.wdata : '0;
    end else if (d_sel) begin
      csb_n = 1'b0;
      we_n  = ~d_port.we;
      addr  = d_port.addr;
      din   = d_port.we ? d_port.wdata : '0;
    end
  end

  assign own_sel  = (state == LOCK_H) ? h_sel       : d_sel;
  assign own_lock = (state == LOCK_H) ? h_port.lock : d_port.lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FREE;
      rr_d     <= 1'b0;
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      if (h_sel)      rr_d <= 1'b1;
      else if (d_sel) rr_d <= 1'b0;
      case (state)
        FREE: begin
          lock_cnt <= '0;
          if (h_sel && h_port.lock)      state <= LOCK_H;
          else if (d_sel && d_port.lock) state <= LOCK_D;
        end
        LOCK_H, LOCK_D: begin
          if (own_sel) begin
            lock_cnt <= '0;
            if (!own_lock) state <= FREE;
          end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            // idle owner timed out: release and hand the next tie to the other side
            state    <= FREE;
            lock_cnt <= '0;
            lock_err <= 1'b1;
            rr_d     <= (state == LOCK_H);
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  sram_rd_return #(.DATA_W(DATA_W)) u_rd_return (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_issue ((h_sel && !h_port.we) || (d_sel && !d_port.we)),
    .rd_owner (d_sel ? REQ_D : REQ_H),
    .dout     (dout),
    .h_rvalid (h_port.rvalid),
    .h_rdata  (h_port.rdata),
    .d_rvalid (d_port.rvalid),
    .d_rdata  (d_port.rdata)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM macro, read-return scoreboard
// and directed arbitration / lock / timeout / reset sequences.
module tb_sram_port_arbiter;
  import sram_pkg::*;

  localparam int LOCK_MAX = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              csb_n, we_n, lock_err;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] mem     [32];
  logic [DATA_W-1:0] ref_mem [32];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    logic              own;
    logic [DATA_W-1:0] data;
    int                due;
  } rd_exp_t;
  rd_exp_t sb[$];

  sram_port_arbiter_if hif ();
  sram_port_arbiter_if dif ();

  sram_port_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .h_port   (hif),
    .d_port   (dif),
    .csb_n    (csb_n),
    .we_n     (we_n),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .lock_err (lock_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!csb_n) begin
      if (!we_n) mem[addr] <= din;
      else       dout      <= mem[addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Scoreboard: reads are queued at their grant, checked two cycles later.
  always @(negedge clk) begin
    rd_exp_t e;
    logic    exp_h, exp_d;
    cyc++;
    if (!rst_n) begin
      sb.delete();
    end else begin
      exp_h = 1'b0;
      exp_d = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (e.own == REQ_H) begin
          exp_h = 1'b1;
          chk("h_rdata", hif.rdata, e.data);
        end else begin
          exp_d = 1'b1;
          chk("d_rdata", dif.rdata, e.data);
        end
      end
      chk("h_rvalid", 32'(hif.rvalid), 32'(exp_h));
      chk("d_rvalid", 32'(dif.rvalid), 32'(exp_d));
      if (hif.req && hif.gnt) begin
        if (hif.we) ref_mem[hif.addr] = hif.wdata;
        else        sb.push_back('{REQ_H, ref_mem[hif.addr], cyc + 2});
      end
      if (dif.req && dif.gnt) begin
        if (dif.we) ref_mem[dif.addr] = dif.wdata;
        else        sb.push_back('{REQ_D, ref_mem[dif.addr], cyc + 2});
      end
    end
  end

  task automatic set_h(input logic req, input logic we, input logic lock,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    hif.req = req; hif.we = we; hif.lock = lock; hif.addr = a; hif.wdata = wd;
  endtask

  task automatic set_d(input logic req, input logic we, input logic lock,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    dif.req = req; dif.we = we; dif.lock = lock; dif.addr = a; dif.wdata = wd;
  endtask

  task automatic idle();
    set_h(1'b0, 1'b0, 1'b0, '0, '0);
    set_d(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) begin smp(); nxt(); end
  endtask

  task automatic wr_h(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    set_h(1'b1, 1'b1, 1'b0, a, wd);
    smp(); chk("wr_h_gnt", 32'(hif.gnt), 32'd1);
    nxt(); idle();
  endtask

  task automatic wr_d(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    set_d(1'b1, 1'b1, 1'b0, a, wd);
    smp(); chk("wr_d_gnt", 32'(dif.gnt), 32'd1);
    nxt(); idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    dout = '0;

    // Reset: outputs quiet even with both requests asserted
    rst_n = 1'b0;
    set_h(1'b1, 1'b1, 1'b0, 5'd9, 32'h1234_5678);
    set_d(1'b1, 1'b0, 1'b0, 5'd4, '0);
    repeat (2) smp();
    chk("rst_h_gnt", 32'(hif.gnt), 32'd0);
    chk("rst_d_gnt", 32'(dif.gnt), 32'd0);
    chk("rst_csb_n", 32'(csb_n), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_h_rvalid", 32'(hif.rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(dif.rvalid), 32'd0);
    chk("rst_h_rdata", hif.rdata, 32'd0);
    chk("rst_lock_err", 32'(lock_err), 32'd0);
    nxt();
    rst_n = 1'b1;
    idle();

    // Host write then read-back of the same address
    set_h(1'b1, 1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF);
    smp();
    chk("t1_w_gnt", 32'(hif.gnt), 32'd1);
    chk("t1_w_csb_n", 32'(csb_n), 32'd0);
    chk("t1_w_we_n", 32'(we_n), 32'd0);
    chk("t1_w_addr", 32'(addr), 32'd3);
    chk("t1_w_din", din, 32'hDEAD_BEEF);
    nxt();
    set_h(1'b1, 1'b0, 1'b0, 5'd3, 32'hFFFF_FFFF);
    smp();
    chk("t1_r_gnt", 32'(hif.gnt), 32'd1);
    chk("t1_r_we_n", 32'(we_n), 32'd1);
    chk("t1_r_din", din, 32'd0);
    chk("t1_r_d_gnt", 32'(dif.gnt), 32'd0);
    nxt();
    drain(3);

    wr_h(5'd1, 32'h1111_1111);
    wr_d(5'd2, 32'h2222_2222);

    // Both requesting continuously: strict alternation, host first
    set_h(1'b1, 1'b0, 1'b0, 5'd1, '0);
    set_d(1'b1, 1'b0, 1'b0, 5'd2, '0);
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("alt_h_gnt", 32'(hif.gnt), 32'((i % 2) == 0));
      chk("alt_d_gnt", 32'(dif.gnt), 32'((i % 2) == 1));
      nxt();
    end
    drain(3);

    // DPU lock across read-compute-write, host blocked meanwhile
    set_h(1'b1, 1'b0, 1'b0, 5'd0, '0);
    set_d(1'b1, 1'b0, 1'b1, 5'd7, '0);
    smp();
    chk("lk_d_gnt0", 32'(dif.gnt), 32'd1);
    chk("lk_h_gnt0", 32'(hif.gnt), 32'd0);
    nxt();
    set_d(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i < 4; i++) begin
      smp();
      chk("lk_h_blocked", 32'(hif.gnt), 32'd0);
      nxt();
    end
    set_d(1'b1, 1'b1, 1'b0, 5'd7, 32'h7777_7777);
    smp();
    chk("lk_d_wr_gnt", 32'(dif.gnt), 32'd1);
    chk("lk_h_gnt4", 32'(hif.gnt), 32'd0);
    nxt();
    set_d(1'b0, 1'b0, 1'b0, '0, '0);
    smp();
    chk("lk_h_after", 32'(hif.gnt), 32'd1);
    nxt();
    drain(3);

    // Lock timeout: DPU locks and goes idle
    set_d(1'b1, 1'b0, 1'b1, 5'd5, '0);
    smp();
    chk("to_d_gnt", 32'(dif.gnt), 32'd1);
    nxt();
    set_d(1'b0, 1'b0, 1'b0, '0, '0);
    set_h(1'b1, 1'b0, 1'b0, 5'd7, '0);
    for (int i = 1; i <= LOCK_MAX; i++) begin
      smp();
      chk("to_h_blocked", 32'(hif.gnt), 32'd0);
      chk("to_no_err", 32'(lock_err), 32'd0);
      nxt();
    end
    set_d(1'b1, 1'b0, 1'b0, 5'd1, '0);
    smp();
    chk("to_lock_err", 32'(lock_err), 32'd1);
    chk("to_h_gnt", 32'(hif.gnt), 32'd1);
    chk("to_d_gnt_tie", 32'(dif.gnt), 32'd0);
    nxt();
    idle();
    smp();
    chk("to_err_pulse", 32'(lock_err), 32'd0);
    nxt();
    drain(3);

    // Back-to-back reads with mixed owners
    wr_h(5'd0, 32'hA0A0_A0A0);
    set_h(1'b1, 1'b0, 1'b0, 5'd0, '0);
    smp(); chk("b2b_h0", 32'(hif.gnt), 32'd1); nxt();
    set_h(1'b0, 1'b0, 1'b0, '0, '0);
    set_d(1'b1, 1'b0, 1'b0, 5'd1, '0);
    smp(); chk("b2b_d1", 32'(dif.gnt), 32'd1); nxt();
    set_d(1'b0, 1'b0, 1'b0, '0, '0);
    set_h(1'b1, 1'b0, 1'b0, 5'd2, '0);
    smp(); chk("b2b_h2", 32'(hif.gnt), 32'd1); nxt();
    drain(3);

    // Reset in the cycle after a read grant drops the pending read
    set_h(1'b1, 1'b0, 1'b0, 5'd3, '0);
    smp(); chk("mr_h_gnt", 32'(hif.gnt), 32'd1); nxt();
    rst_n = 1'b0;
    idle();
    smp();
    chk("mr_csb_n", 32'(csb_n), 32'd1);
    chk("mr_we_n", 32'(we_n), 32'd1);
    chk("mr_lock_err", 32'(lock_err), 32'd0);
    chk("mr_h_rvalid", 32'(hif.rvalid), 32'd0);
    nxt();
    smp(); nxt();
    rst_n = 1'b1;
    drain(3);
    set_h(1'b1, 1'b0, 1'b0, 5'd1, '0);
    set_d(1'b1, 1'b0, 1'b0, 5'd2, '0);
    smp();
    chk("mr_h_first", 32'(hif.gnt), 32'd1);
    chk("mr_d_wait", 32'(dif.gnt), 32'd0);
    nxt();
    drain(3);

    if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
